mac_operand_rx: RTL and testbench

MAC_OPERAND_RX -- requirements
Module: mac_operand_rx

---
 rtl/mac_pkg.sv | 32 +++
 rtl/sync_bit.sv | 30 +++
 rtl/mac_operand_rx.sv | 186 ++++++++++++++++++
 tb/tb_mac_operand_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the SPI operand receiver: receiver states,
// default frame size, command-frame header layout and header check.
package mac_pkg;

    localparam int FRAME_BITS_DEF = 24;

    // Header and field positions within a received command frame.
    localparam int OP_BIT = 23;
    localparam int SEL_HI = 22;
    localparam int SEL_LO = 20;
    localparam int RSV_HI = 19;
    localparam int RSV_LO = 16;
    localparam int A_HI   = 15;
    localparam int A_LO   = 8;
    localparam int C_HI   = 7;
    localparam int C_LO   = 0;

    localparam logic MAC_OP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FULL,
        ST_WAIT_IDLE
    } rx_state_e;

    // A frame is accepted only as a MAC op with the reserved nibble clear.
    function automatic logic hdr_ok(input logic [FRAME_BITS_DEF-1:0] f);
        return (f[OP_BIT] == MAC_OP) && (f[RSV_HI:RSV_LO] == 4'b0000);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input pin.
// Ports: clk, rst (sync, active high), d (async in), q (synchronized out).
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mac_operand_rx.sv
// SPI (mode 0) command receiver that issues MAC operands and a strobe.
// Ports: clk/rst, sclk/cs_n/mosi (async SPI in), A_in/C_in/sel (operands),
// aluop_st2 (issue strobe), frame_err, busy, op_cnt (issued-op count).
module mac_operand_rx
    import mac_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic signed [7:0] A_in,
    output logic signed [7:0] C_in,
    output logic        [2:0] sel,
    output logic              aluop_st2,
    output logic              frame_err,
    output logic              busy,
    output logic        [7:0] op_cnt
);

    localparam int CNT_W     = $clog2(FRAME_BITS + 1);
    // Cycles after reset until the synchronizers and edge detectors
    // reflect the real pins rather than their reset levels.
    localparam int PRIME_MAX = SYNC_STAGES + 2;
    localparam int PRIME_W   = $clog2(PRIME_MAX + 1);

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk),
        .rst (rst),
        .d   (cs_n),
        .q   (cs_n_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    // Registered edge events; mosi is delayed one cycle so it lines up
    // with the registered sclk rise.
    logic sclk_d1_q, sclk_d1_d;
    logic cs_n_d1_q, cs_n_d1_d;
    logic mosi_d1_q, mosi_d1_d;
    logic sclk_rise_q, sclk_rise_d;
    logic cs_rise_q, cs_rise_d;
    logic cs_fall_q, cs_fall_d;

    always_comb begin
        sclk_d1_d   = sclk_s;
        cs_n_d1_d   = cs_n_s;
        mosi_d1_d   = mosi_s;
        sclk_rise_d = sclk_s & ~sclk_d1_q;
        cs_rise_d   = cs_n_s & ~cs_n_d1_q;
        cs_fall_d   = ~cs_n_s & cs_n_d1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d1_q   <= 1'b0;
            cs_n_d1_q   <= 1'b1;
            mosi_d1_q   <= 1'b0;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sclk_d1_q   <= sclk_d1_d;
            cs_n_d1_q   <= cs_n_d1_d;
            mosi_d1_q   <= mosi_d1_d;
            sclk_rise_q <= sclk_rise_d;
            cs_rise_q   <= cs_rise_d;
            cs_fall_q   <= cs_fall_d;
        end
    end

    rx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic [7:0]            a_q;
    logic [7:0]            c_q;
    logic [2:0]            sel_q;
    logic                  aluop_q;
    logic                  ferr_q;
    logic [7:0]            op_cnt_q;
    logic [PRIME_W-1:0]    prime_q;
    // Set when a frame was cut by reset: its closing cs_n rise is silent.
    logic                  quiet_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            a_q      <= '0;
            c_q      <= '0;
            sel_q    <= '0;
            aluop_q  <= 1'b0;
            ferr_q   <= 1'b0;
            op_cnt_q <= '0;
            prime_q  <= '0;
            quiet_q  <= 1'b0;
        end else begin
            aluop_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (prime_q != PRIME_W'(PRIME_MAX)) begin
                // Edges seen here are reset artefacts; a low cs_n means
                // we joined mid-frame, so wait it out quietly.
                prime_q <= prime_q + 1'b1;
                state_q <= cs_n_s ? ST_IDLE : ST_WAIT_IDLE;
                quiet_q <= ~cs_n_s;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (cs_fall_q) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= '0;
                            shift_q <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (cs_rise_q) begin
                            ferr_q  <= (cnt_q != '0);
                            state_q <= ST_IDLE;
                        end else if (sclk_rise_q) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], mosi_d1_q};
                            cnt_q   <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                                state_q <= ST_FULL;
                            end
                        end
                    end
                    ST_FULL: begin
                        if (cs_rise_q) begin
                            if (hdr_ok(shift_q[FRAME_BITS_DEF-1:0])) begin
                                a_q      <= shift_q[A_HI:A_LO];
                                c_q      <= shift_q[C_HI:C_LO];
                                sel_q    <= shift_q[SEL_HI:SEL_LO];
                                aluop_q  <= 1'b1;
                                op_cnt_q <= op_cnt_q + 8'd1;
                            end else begin
                                ferr_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end else if (sclk_rise_q) begin
                            state_q <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (cs_rise_q) begin
                            ferr_q  <= ~quiet_q;
                            quiet_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign A_in      = a_q;
    assign C_in      = c_q;
    assign sel       = sel_q;
    assign aluop_st2 = aluop_q;
    assign frame_err = ferr_q;
    assign busy      = ~cs_n_s;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_mac_operand_rx.sv
// Scoreboard bench for mac_operand_rx: directed SPI frames push expected
// events; a monitor pops and checks them whenever the DUT pulses.
module tb_mac_operand_rx;

    localparam int LAT  = 2 + 2;
    localparam int HALF = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic signed [7:0] A_in;
    logic signed [7:0] C_in;
    logic        [2:0] sel;
    logic              aluop_st2;
    logic              frame_err;
    logic              busy;
    logic        [7:0] op_cnt;

    mac_operand_rx #(.FRAME_BITS(24), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .A_in      (A_in),
        .C_in      (C_in),
        .sel       (sel),
        .aluop_st2 (aluop_st2),
        .frame_err (frame_err),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         issue;
        logic [7:0] a;
        logic [7:0] c;
        logic [2:0] sel;
        logic [7:0] cnt;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_strobe = -1;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_c = 8'd0;
    logic [2:0] m_sel = 3'd0;
    logic [7:0] m_cnt = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (aluop_st2 || frame_err)) begin
            checks++;
            if (aluop_st2 && frame_err) begin
                errors++;
                $display("FAIL both_pulses: aluop=1 frame_err=1 at cyc %0d", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected: aluop=%0b err=%0b, none required",
                         aluop_st2, frame_err);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (aluop_st2 !== e.issue || A_in !== e.a || C_in !== e.c ||
                    sel !== e.sel || op_cnt !== e.cnt ||
                    cyc != e.cyc + LAT) begin
                    errors++;
                    $display("FAIL event: got issue=%0b A=%h C=%h sel=%0d cnt=%0d lat=%0d, want issue=%0b A=%h C=%h sel=%0d cnt=%0d lat=%0d",
                             aluop_st2, A_in, C_in, sel, op_cnt, cyc - e.cyc,
                             e.issue, e.a, e.c, e.sel, e.cnt, LAT);
                end
            end
            if (aluop_st2) begin
                if (last_strobe >= 0) begin
                    checks++;
                    if (cyc - last_strobe < 3) begin
                        errors++;
                        $display("FAIL strobe_gap: got %0d cycles, want >= 3",
                                 cyc - last_strobe);
                    end
                end
                last_strobe = cyc;
            end
        end
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic spi_start();
        cs_n = 1'b0;
        clk_n(HALF);
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            clk_n(HALF);
            sclk = 1'b1;
            clk_n(HALF);
            sclk = 1'b0;
        end
    endtask

    // kind: 0 none, 1 issue, 2 frame error.
    task automatic spi_end(input int kind, input logic [23:0] f);
        ev_t e;
        clk_n(HALF);
        if (kind == 1) begin
            m_a   = f[15:8];
            m_c   = f[7:0];
            m_sel = f[22:20];
            m_cnt = m_cnt + 8'd1;
        end
        e.issue = (kind == 1);
        e.a     = m_a;
        e.c     = m_c;
        e.sel   = m_sel;
        e.cnt   = m_cnt;
        e.cyc   = cyc;
        if (kind != 0) exp_q.push_back(e);
        cs_n = 1'b1;
        clk_n(12);
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int kind);
        spi_start();
        spi_bits(v, n);
        spi_end(kind, v[23:0]);
    endtask

    task automatic model_reset();
        m_a   = 8'd0;
        m_c   = 8'd0;
        m_sel = 3'd0;
        m_cnt = 8'd0;
        last_strobe = -1;
    endtask

    initial begin
        rst = 1'b1;
        clk_n(4);
        rst = 1'b0;
        model_reset();
        clk_n(8);

        chk("rst_A", int'(A_in), 0);
        chk("rst_C", int'(C_in), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_cnt", int'(op_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_aluop", int'(aluop_st2), 0);
        chk("rst_ferr", int'(frame_err), 0);

        // Valid frame: A=5, C=-3, sel=4.
        spi_start();
        chk("busy_low_cs", int'(busy), 1);
        spi_bits(32'hC005FD, 24);
        spi_end(1, 24'hC005FD);
        chk("busy_idle", int'(busy), 0);

        // Empty frame is silent.
        frame(32'h0, 0, 0);
        // Short, long and bad-header frames.
        frame(32'hC005, 16, 2);
        frame(32'h180BFB, 25, 2);
        frame(32'h4005FD, 24, 2);
        frame(32'hC105FD, 24, 2);
        chk("cnt_after_errs", int'(op_cnt), 1);

        // Reset mid-frame, the rest of that frame is discarded silently.
        spi_start();
        spi_bits(32'h3A5, 10);
        rst = 1'b1;
        clk_n(3);
        rst = 1'b0;
        model_reset();
        spi_bits(32'h2A5B, 14);
        spi_end(0, 24'h0);
        chk("cut_cnt", int'(op_cnt), 0);
        chk("cut_A", int'(A_in), 0);
        frame(32'h800102, 24, 1);
        chk("post_cut_cnt", int'(op_cnt), 1);

        // 256 back-to-back frames from a fresh count: wraps to 0.
        rst = 1'b1;
        clk_n(3);
        rst = 1'b0;
        model_reset();
        clk_n(8);
        for (int i = 0; i < 256; i++) begin
            logic [7:0]  a;
            logic [7:0]  c;
            logic [2:0]  s;
            logic [31:0] f;
            a = 8'(i);
            c = 8'(255 - i);
            s = 3'(i % 8);
            f = {8'h00, 1'b1, s, 4'b0000, a, c};
            frame(f, 24, 1);
        end
        chk("wrap_cnt", int'(op_cnt), 0);
        chk("last_A", int'(A_in), -1);
        chk("last_C", int'(C_in), 0);
        chk("last_sel", int'(sel), 7);

        clk_n(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
